alu_acc_seq: RTL
================

# alu_acc_seq

Command sequencer for the accumulator datapath: accepts one ALU command at a time over a valid/ready handshake and drives the C8–C21 control lines of the accumulator/ALU block. It can repeat the command for up to 16 consecutive cycles, with optional early stop on zero. It reports completion with the resulting flags. The accumulator registers every clock, so this block owns the cycle-by-cycle control word.

## Interface
- No parameters. Opcode map and repeat width are fixed.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-high (rst_n=1 resets on the next rising edge).
- cmd_valid  in  1  command present.
- cmd_op  in  4  opcode (map below).
- cmd_rep  in  4  extra repetitions; the op executes cmd_rep+1 cycles.
- cmd_untz  in  1  stop early when ZF=1 (ALUflags[3]).
- cmd_ready  out  1  high only in IDLE.
- ALUflags  in  4  registered flags {ZF,CF,OF,SF} from the accumulator block.
- C8, C9, C13, C15, C16, C17, C18, C19, C20, C21  out  1 each  ALU control lines; at most one high per cycle.
- busy  out  1  high in EXEC and DONE.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  one-cycle pulse when an illegal opcode is accepted.
- res_flags  out  4  ALUflags captured in DONE; held until the next DONE.
- res_cycles  out  5  number of EXEC cycles that asserted a C line, captured in DONE (1..16).

## Operation
- Opcode map: 0x0 NOP (no line, still sequences); 0x1 C8; 0x2 C9; 0x3 C13; 0x4 C15; 0x5 C16; 0x6 C17; 0x7 C18; 0x8 C19; 0x9 C20; 0xA C21; 0xB–0xF illegal.
- All C lines low means the datapath holds ACC. The block drives all-low in every state except a qualifying EXEC cycle.
- States: IDLE, EXEC, DONE.
- IDLE: cmd_ready=1. Handshake at a rising edge with cmd_valid=1 latches op, rep, and untz, and loads the remaining-count register with cmd_rep.
  - Legal op: next state EXEC.
  - Illegal op: err=1 for the next cycle, state stays IDLE, no C line asserted, res_* unchanged.
- EXEC: assert the latched op's C line combinationally from state.
  - Remaining count 0: next state DONE.
  - Otherwise decrement the count and stay in EXEC.
- Early stop: in any EXEC cycle other than the first, if untz=1 and ALUflags[3]=1, assert no C line that cycle and go to DONE. That cycle is not counted in res_cycles.
  - The first EXEC cycle ignores ZF, because the flags are from before the command.
- DONE: done=1, busy=1, cmd_ready=0. At the closing edge, res_flags<=ALUflags and res_cycles<=executed count. Next state IDLE.
- cmd_op/cmd_rep/cmd_untz are sampled only at the handshake; changes while busy are ignored.
- The cycle counter is 5 bits and cannot overflow (maximum 16).

## Timing
- Reset values: state IDLE; cmd_ready=1 (after reset, in IDLE); all C lines 0; busy 0; done 0; err 0; res_flags 0; res_cycles 0.
- Reset mid-EXEC or mid-DONE: C lines go low and done is not pulsed; the command is discarded.
- Handshake at edge T: first C-line cycle is T..T+1, last is T+cmd_rep. DONE occupies the cycle after the last EXEC cycle; IDLE follows.
  - Total occupancy: cmd_rep+3 cycles from handshake edge to the next possible handshake edge.
- In DONE, ALUflags already reflects the final ALU result (the accumulator registers at the end of the last EXEC cycle). res_flags is therefore exact.
- Outputs C*, busy, cmd_ready, and done are decoded from registered state with no input-to-output combinational path.
  - Exception: the early-stop gating of C lines by ALUflags[3], which comes from a register in the accumulator block.
- No back-to-back acceptance: a command cannot be accepted in DONE.

## Test plan
- Reset, then op 0x2 (C9), rep 0 -> C9 high exactly 1 cycle; done 1 cycle later; res_cycles=1; cmd_ready low for 2 cycles.
- Op 0x6 (C17), rep 3, with ACC=0x0001 in an integrated bench -> C17 high 4 consecutive cycles; ACC=0x0010; res_cycles=4.
- Op 0x3 (C13), rep 15, untz=1, integrated with BR=1 and ACC=3 -> C13 high 3 cycles, then stop; ACC=0; res_flags[3]=1; res_cycles=3.
- Op 0xC -> err pulse 1 cycle, no C line, no done, res_* unchanged, cmd_ready stays 1.
- Assert rst_n during the 2nd EXEC cycle of rep=5 -> all C lines 0 on the next edge; no done; IDLE; cmd_ready=1.
- cmd_valid held high with changing cmd_op during EXEC -> only the latched op is driven; the next command is accepted only in IDLE.

Source files
------------

// File: rtl/alu_acc_seq.sv
// Runs one ALU command for up to 16 cycles and reports completion with the resulting flags.
// Latency: cmd_rep+3 cycles between accepts; backpressure: cmd_ready only in IDLE, so nothing is accepted while busy.
module alu_acc_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_rep,
    input  logic       cmd_untz,
    output logic       cmd_ready,
    input  logic [3:0] ALUflags,
    output logic       C8,
    output logic       C9,
    output logic       C13,
    output logic       C15,
    output logic       C16,
    output logic       C17,
    output logic       C18,
    output logic       C19,
    output logic       C20,
    output logic       C21,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] res_flags,
    output logic [4:0] res_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [3:0] op_q;
    logic [3:0] rem_q;
    logic       untz_q;
    logic       first_q;
    logic [4:0] cnt_q;

    logic       accept;
    logic       op_legal;
    logic       stop;
    logic       fire;
    logic [9:0] lines;

    // ZF is only trusted after the first EXEC cycle; before that it reflects the previous command.
    always_comb begin
        accept   = (state == S_IDLE) && cmd_valid;
        op_legal = (cmd_op <= 4'hA);
        stop     = (state == S_EXEC) && untz_q && !first_q && ALUflags[3];
        fire     = (state == S_EXEC) && !stop;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && op_legal) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (stop || (rem_q == 4'd0)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        lines = 10'b0;
        if (fire) begin
            case (op_q)
                4'h1:    lines[0] = 1'b1;
                4'h2:    lines[1] = 1'b1;
                4'h3:    lines[2] = 1'b1;
                4'h4:    lines[3] = 1'b1;
                4'h5:    lines[4] = 1'b1;
                4'h6:    lines[5] = 1'b1;
                4'h7:    lines[6] = 1'b1;
                4'h8:    lines[7] = 1'b1;
                4'h9:    lines[8] = 1'b1;
                4'hA:    lines[9] = 1'b1;
                default: lines    = 10'b0;
            endcase
        end
    end

    assign C8        = lines[0];
    assign C9        = lines[1];
    assign C13       = lines[2];
    assign C15       = lines[3];
    assign C16       = lines[4];
    assign C17       = lines[5];
    assign C18       = lines[6];
    assign C19       = lines[7];
    assign C20       = lines[8];
    assign C21       = lines[9];

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= S_IDLE;
            op_q       <= 4'd0;
            rem_q      <= 4'd0;
            untz_q     <= 1'b0;
            first_q    <= 1'b0;
            cnt_q      <= 5'd0;
            err        <= 1'b0;
            res_flags  <= 4'd0;
            res_cycles <= 5'd0;
        end else begin
            state <= state_nxt;
            err   <= accept && !op_legal;
            case (state)
                S_IDLE: begin
                    if (accept && op_legal) begin
                        op_q    <= cmd_op;
                        rem_q   <= cmd_rep;
                        untz_q  <= cmd_untz;
                        first_q <= 1'b1;
                        cnt_q   <= 5'd0;
                    end
                end
                S_EXEC: begin
                    if (!stop) begin
                        cnt_q   <= cnt_q + 5'd1;
                        first_q <= 1'b0;
                        if (rem_q != 4'd0) begin
                            rem_q <= rem_q - 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    res_flags  <= ALUflags;
                    res_cycles <= cnt_q;
                end
                default: begin
                    first_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
